// File: rtl/dmem_sched.sv
// dmem_sched: two-requester (core LSU = r0, DMA = r1) scheduler in front of a
// single 32-bit word memory. Grants round-robin, splits misaligned accesses
// into two word beats, and merges split load data before responding.
//
// Handshake: a request on rN transfers on a rising edge where req_valid[N]
// and req_ready[N] are both high; req_ready is offered only in IDLE, to at
// most one requester, and a requester may withdraw valid before that edge.
module dmem_sched (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req_we,
    input  logic [63:0] req_addr,
    input  logic [3:0]  req_size,
    input  logic [63:0] req_wdata,
    output logic [1:0]  rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state;
    logic        last_grant;
    logic        grant_idx;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [1:0]  lat_size;
    logic [31:0] lat_wdata;
    logic [31:0] d0;

    // Arbitration and the fields of the selected requester.
    logic        grant_sel;
    logic        accept;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [1:0]  sel_size;
    logic [31:0] sel_wdata;

    // Geometry of the latched request.
    logic [1:0]  off;
    logic [2:0]  off3;
    logic [3:0]  nbytes;
    logic [3:0]  byte_mask;
    logic [31:0] data_mask;
    logic        split;
    logic [5:0]  sh0;
    logic [5:0]  sh1;
    logic [31:0] base;

    // Round-robin choice: a lone requester wins, a tie goes to the one not granted last.
    always_comb begin
        grant_sel = 1'b0;
        case (req_valid)
            2'b01:   grant_sel = 1'b0;
            2'b10:   grant_sel = 1'b1;
            2'b11:   grant_sel = ~last_grant;
            default: grant_sel = 1'b0;
        endcase
        accept    = (state == IDLE) && !rst && (req_valid != 2'b00);
        req_ready = 2'b00;
        if (accept) begin
            req_ready = grant_sel ? 2'b10 : 2'b01;
        end
        sel_we    = grant_sel ? req_we[1]         : req_we[0];
        sel_addr  = grant_sel ? req_addr[63:32]   : req_addr[31:0];
        sel_size  = grant_sel ? req_size[3:2]     : req_size[1:0];
        sel_wdata = grant_sel ? req_wdata[63:32]  : req_wdata[31:0];
    end

    // Byte offset, access width and split detection for the request in flight.
    always_comb begin
        off  = lat_addr[1:0];
        off3 = {1'b0, off};
        base = {lat_addr[31:2], 2'b00};
        sh0  = {1'b0, off, 3'b000};
        sh1  = 6'd32 - sh0;
        case (lat_size)
            2'b00: begin nbytes = 4'd1; byte_mask = 4'b0001; data_mask = 32'h0000_00FF; end
            2'b01: begin nbytes = 4'd2; byte_mask = 4'b0011; data_mask = 32'h0000_FFFF; end
            2'b10: begin nbytes = 4'd4; byte_mask = 4'b1111; data_mask = 32'hFFFF_FFFF; end
            default: begin nbytes = 4'd0; byte_mask = 4'b0000; data_mask = 32'h0000_0000; end
        endcase
        split = ({2'b00, off} + nbytes) > 4'd4;
    end

    // Output decode from the current state; everything idles at zero outside the beats.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'h0;
        mem_be    = 4'b0000;
        mem_wdata = 32'h0;
        rsp_valid = 2'b00;
        rsp_err   = 1'b0;
        rsp_rdata = 32'h0;
        case (state)
            BEAT0: begin
                mem_en    = 1'b1;
                mem_we    = lat_we;
                mem_addr  = base;
                mem_be    = byte_mask << off;
                mem_wdata = lat_wdata << sh0;
            end
            BEAT1: begin
                mem_en    = 1'b1;
                mem_we    = lat_we;
                mem_addr  = base + 32'd4;
                mem_be    = byte_mask >> (3'd4 - off3);
                mem_wdata = lat_wdata >> sh1;
            end
            RESP: begin
                rsp_valid = grant_idx ? 2'b10 : 2'b01;
                rsp_err   = (lat_size == 2'b11);
                if (!lat_we && (lat_size != 2'b11)) begin
                    // Split loads stitch the low part of beat 0 under the high part of beat 1.
                    if (split) begin
                        rsp_rdata = ((d0 >> sh0) | (mem_rdata << sh1)) & data_mask;
                    end else begin
                        rsp_rdata = (mem_rdata >> sh0) & data_mask;
                    end
                end
            end
            default: ;
        endcase
    end

    // Sequencer: latch on accept, walk the beats, pulse the response, return to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant_idx  <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= 32'h0;
            lat_size   <= 2'b00;
            lat_wdata  <= 32'h0;
            d0         <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        last_grant <= grant_sel;
                        grant_idx  <= grant_sel;
                        lat_we     <= sel_we;
                        lat_addr   <= sel_addr;
                        lat_size   <= sel_size;
                        lat_wdata  <= sel_wdata;
                        state      <= (sel_size == 2'b11) ? RESP : BEAT0;
                    end
                end
                BEAT0: begin
                    state <= split ? BEAT1 : RESP;
                end
                BEAT1: begin
                    // Beat-0 read data is on mem_rdata during this cycle.
                    d0    <= mem_rdata;
                    state <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_sched.sv
// Bench for dmem_sched: a word memory responder, a byte-addressed reference
// memory, a table of directed vectors, round-robin and reset sequences, and
// randomized single requests checked against the byte model.
module tb_dmem_sched;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_we;
    logic [63:0] req_addr;
    logic [3:0]  req_size;
    logic [63:0] req_wdata;
    logic [1:0]  rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int tests = 0;
    int fails = 0;

    dmem_sched dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word memory seen by the DUT, and byte-level reference memory.
    logic [31:0] wmem [logic [31:0]];
    logic [7:0]  bmem [logic [31:0]];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h0123_4567;
    endfunction

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        if (wmem.exists(a)) return wmem[a];
        return init_word(a);
    endfunction

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                logic [31:0] w;
                w = rd_word(mem_addr);
                for (int l = 0; l < 4; l++)
                    if (mem_be[l]) w[8*l +: 8] = mem_wdata[8*l +: 8];
                wmem[mem_addr] = w;
            end else begin
                mem_rdata <= rd_word(mem_addr);
            end
        end
    end

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        logic [31:0] w;
        if (bmem.exists(a)) return bmem[a];
        w = init_word({a[31:2], 2'b00});
        return w[8*a[1:0] +: 8];
    endfunction

    function automatic int size_bytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : (s == 2'd2) ? 4 : 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input int n);
        logic [31:0] v;
        v = 32'h0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_rd(a + 32'(i));
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input int n, input logic [31:0] d);
        for (int i = 0; i < n; i++) bmem[a + 32'(i)] = d[8*i +: 8];
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] w);
        wmem[a] = w;
        for (int i = 0; i < 4; i++) bmem[a + 32'(i)] = w[8*i +: 8];
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Observations from one transaction.
    int          obs_nb, obs_rsp_cyc, obs_extra, obs_quiet_bad;
    bit          obs_timeout;
    logic [31:0] obs_addr [2];
    logic [3:0]  obs_be [2];
    logic [31:0] obs_wd [2];
    logic        obs_we [2];
    logic [1:0]  obs_rv;
    logic [31:0] obs_rdata;
    logic        obs_err;

    task automatic set_req(input int r, input logic we, input logic [31:0] addr,
                           input logic [1:0] size, input logic [31:0] wdata);
        if (r == 0) begin
            req_we[0] = we; req_addr[31:0] = addr; req_size[1:0] = size; req_wdata[31:0] = wdata;
        end else begin
            req_we[1] = we; req_addr[63:32] = addr; req_size[3:2] = size; req_wdata[63:32] = wdata;
        end
    endtask

    // Driver: offer one request on requester r, then record five cycles after the accept edge.
    task automatic run_req(input int r, input logic we, input logic [31:0] addr,
                           input logic [1:0] size, input logic [31:0] wdata);
        bit got;
        obs_nb = 0; obs_rsp_cyc = 0; obs_extra = 0; obs_quiet_bad = 0; obs_timeout = 0;
        obs_rv = 2'b00; obs_rdata = 32'h0; obs_err = 1'b0;
        @(posedge clk); #1;
        set_req(r, we, addr, size, wdata);
        req_valid = (r == 0) ? 2'b01 : 2'b10;
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            if (req_ready == req_valid) got = 1;
        end
        if (!got) begin
            obs_timeout = 1;
            req_valid = 2'b00;
            return;
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (mem_en) begin
                if (obs_nb < 2) begin
                    obs_addr[obs_nb] = mem_addr; obs_be[obs_nb] = mem_be;
                    obs_wd[obs_nb] = mem_wdata;  obs_we[obs_nb] = mem_we;
                end
                obs_nb++;
            end else if (mem_we || mem_be != 4'b0 || mem_wdata != 32'h0) begin
                obs_quiet_bad++;
            end
            if (rsp_valid != 2'b00) begin
                if (obs_rsp_cyc == 0) begin
                    obs_rsp_cyc = k; obs_rv = rsp_valid; obs_rdata = rsp_rdata; obs_err = rsp_err;
                end else begin
                    obs_extra++;
                end
            end
        end
    endtask

    // Scoreboard: check a transaction against the byte model, then update the model.
    task automatic check_model(input string tag, input int r, input logic we, input logic [31:0] addr,
                               input logic [1:0] size, input logic [31:0] wdata);
        int n, exp_nb, exp_lat, be_bytes;
        logic [31:0] exp_rd;
        logic [31:0] exp_q[$];
        n = size_bytes(size);
        exp_nb  = (size == 2'd3) ? 0 : ((int'(addr[1:0]) + n > 4) ? 2 : 1);
        exp_lat = exp_nb + 1;
        exp_rd  = (we || size == 2'd3) ? 32'h0 : ref_load(addr, n);
        exp_q.push_back(exp_rd);
        run_req(r, we, addr, size, wdata);
        chk({tag, "_timeout"}, 32'(obs_timeout), 32'h0);
        if (obs_timeout) return;
        chk({tag, "_beats"}, obs_nb, exp_nb);
        chk({tag, "_latency"}, obs_rsp_cyc, exp_lat);
        chk({tag, "_rsp_valid"}, 32'(obs_rv), (r == 0) ? 32'h1 : 32'h2);
        chk({tag, "_rsp_extra"}, obs_extra, 0);
        chk({tag, "_rsp_err"}, 32'(obs_err), 32'(size == 2'd3));
        chk({tag, "_rdata"}, obs_rdata, exp_q.pop_front());
        chk({tag, "_idle_zero"}, obs_quiet_bad, 0);
        be_bytes = 0;
        if (obs_nb >= 1) begin
            chk({tag, "_addr0"}, obs_addr[0], {addr[31:2], 2'b00});
            chk({tag, "_we0"}, 32'(obs_we[0]), 32'(we));
            be_bytes += $countones(obs_be[0]);
        end
        if (obs_nb >= 2) begin
            chk({tag, "_addr1"}, obs_addr[1], {addr[31:2], 2'b00} + 32'd4);
            be_bytes += $countones(obs_be[1]);
        end
        chk({tag, "_be_bytes"}, be_bytes, n);
        if (we && size != 2'd3) ref_store(addr, n, wdata);
    endtask

    typedef struct {
        int          r;
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [3:0]  be0;
        logic [31:0] wd0;
        logic [3:0]  be1;
        logic [31:0] wd1;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int grants [4];
        int ng, both_bad, rv_seen;
        req_valid = 2'b00; req_we = 2'b00; req_addr = 64'h0; req_size = 4'h0; req_wdata = 64'h0;
        mem_rdata = 32'h0;

        vecs[0] = '{0, 1'b1, 32'h0000_0100, 2'd2, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 4'b0000, 32'h0, 32'h0};
        vecs[1] = '{1, 1'b0, 32'h0000_0203, 2'd2, 32'h0,         4'b1000, 32'h0,         4'b0111, 32'h0, 32'h7766_5544};
        vecs[2] = '{0, 1'b1, 32'h0000_0013, 2'd1, 32'h0000_ABCD, 4'b1000, 32'hCD00_0000, 4'b0001, 32'h0000_00AB, 32'h0};
        vecs[3] = '{0, 1'b0, 32'hFFFF_FFFF, 2'd0, 32'h0,         4'b1000, 32'h0,         4'b0000, 32'h0, 32'h0000_00AA};
        vecs[4] = '{1, 1'b0, 32'hFFFF_FFFE, 2'd2, 32'h0,         4'b1100, 32'h0,         4'b0011, 32'h0, 32'h0201_AA00};
        vecs[5] = '{0, 1'b0, 32'h0000_0040, 2'd3, 32'h0,         4'b0000, 32'h0,         4'b0000, 32'h0, 32'h0};
        vecs[6] = '{1, 1'b0, 32'h0000_0202, 2'd1, 32'h0,         4'b1100, 32'h0,         4'b0000, 32'h0, 32'h0000_4433};
        vecs[7] = '{0, 1'b0, 32'h0000_0100, 2'd2, 32'h0,         4'b1111, 32'h0,         4'b0000, 32'h0, 32'hDEAD_BEEF};
        vecs[8] = '{1, 1'b1, 32'h0000_0105, 2'd0, 32'h0000_005A, 4'b0010, 32'h0000_5A00, 4'b0000, 32'h0, 32'h0};

        preload(32'h0000_0200, 32'h4433_2211);
        preload(32'h0000_0204, 32'h8877_6655);
        preload(32'hFFFF_FFFC, 32'hAA00_0000);
        preload(32'h0000_0000, 32'h0403_0201);

        // Reset and reset-state check
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready_rsp", {28'h0, req_ready, rsp_valid}, 32'h0);
        chk("rst_mem_ctl", {26'h0, mem_en, mem_we, mem_be}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_rsp_data", {rsp_rdata[30:0], rsp_err}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Round robin with both requesters valid continuously
        set_req(0, 1'b0, 32'h0000_0300, 2'd2, 32'h0);
        set_req(1, 1'b0, 32'h0000_0304, 2'd2, 32'h0);
        req_valid = 2'b11;
        ng = 0; both_bad = 0;
        for (int k = 0; k < 40 && ng < 4; k++) begin
            @(negedge clk);
            if (req_ready == 2'b11) both_bad++;
            if (req_ready != 2'b00) begin
                grants[ng] = req_ready[1] ? 1 : 0;
                ng++;
            end
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        chk("rr_grant_count", ng, 4);
        chk("rr_never_both", both_bad, 0);
        if (ng == 4) begin
            for (int i = 0; i < 4; i++) chk($sformatf("rr_grant%0d", i), grants[i], i % 2);
        end
        repeat (6) @(posedge clk);

        // Directed vectors: exact beat shapes plus the model checks
        for (int i = 0; i < 9; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            check_model(tag, vecs[i].r, vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].wdata);
            chk({tag, "_exp_rdata"}, obs_rdata, vecs[i].rdata);
            chk({tag, "_be0"}, (obs_nb >= 1) ? 32'(obs_be[0]) : 32'h0, 32'(vecs[i].be0));
            chk({tag, "_wd0"}, (obs_nb >= 1) ? obs_wd[0] : 32'h0, vecs[i].wd0);
            chk({tag, "_be1"}, (obs_nb >= 2) ? 32'(obs_be[1]) : 32'h0, 32'(vecs[i].be1));
            chk({tag, "_wd1"}, (obs_nb >= 2) ? obs_wd[1] : 32'h0, vecs[i].wd1);
        end

        // Reset in BEAT1 abandons the transaction
        @(posedge clk); #1;
        set_req(0, 1'b0, 32'h0000_0203, 2'd2, 32'h0);
        req_valid = 2'b01;
        ng = 0;
        for (int k = 0; k < 10 && ng == 0; k++) begin
            @(negedge clk);
            if (req_ready == 2'b01) ng = 1;
        end
        chk("rstmid_accept", ng, 1);
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_in_beat1", {mem_en, mem_addr[30:0]}, {1'b1, 31'h0000_0204});
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_state", 32'(dut.state), 32'h0);
        chk("rstmid_outs", {24'h0, req_ready, rsp_valid, rsp_err, mem_en, mem_we, 1'b0}, 32'h0);
        chk("rstmid_be_addr", {mem_be, mem_addr[27:0]}, 32'h0);
        chk("rstmid_data", mem_wdata | rsp_rdata, 32'h0);
        rv_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid != 2'b00) rv_seen++;
        end
        chk("rstmid_no_rsp", rv_seen, 0);

        // Randomized single requests against the byte model
        for (int i = 0; i < 150; i++) begin
            int r, sz_pick;
            logic [31:0] a;
            logic [1:0]  s;
            r = $urandom_range(0, 1);
            a = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255)) : 32'($urandom);
            sz_pick = $urandom_range(0, 9);
            s = (sz_pick < 3) ? 2'd0 : (sz_pick < 6) ? 2'd1 : (sz_pick < 9) ? 2'd2 : 2'd3;
            check_model($sformatf("rnd%0d", i), r, 1'($urandom_range(0, 1)), a, s, 32'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmem_sched.md
DMEM_SCHED -- requirements
Module: dmem_sched

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk rising-edge; rst synchronous, active-high.
REQ-002 The ports SHALL be (name direction width meaning):
  clk  in  1  clock
  rst  in  1  synchronous active-high reset
  req_valid  in  2  request valid; bit0 = core LSU, bit1 = DMA
  req_ready  out  2  request accepted this cycle (one-hot or zero)
  req_we  in  2  1 = store, 0 = load
  req_addr  in  64  byte addresses {r1[31:0], r0[31:0]}
  req_size  in  4  {r1,r0}; 00 byte, 01 half, 10 word, 11 illegal
  req_wdata  in  64  store data, right-justified {r1, r0}
  rsp_valid  out  2  one-cycle completion pulse to the granted requester
  rsp_err  out  1  illegal size; qualified by rsp_valid
  rsp_rdata  out  32  load data, right-justified, zero-extended
  mem_en  out  1  memory access this cycle
  mem_we  out  1  write strobe
  mem_addr  out  32  word-aligned address, bits[1:0] = 0
  mem_be  out  4  byte enables
  mem_wdata  out  32  byte-lane-aligned write data
  mem_rdata  in  32  read data, valid the cycle after mem_en with mem_we = 0

Function
REQ-003 The FSM SHALL have four states: IDLE, BEAT0, BEAT1, RESP.
REQ-004 req_ready SHALL be high only in IDLE, for exactly one requester whose req_valid is high.
REQ-005 Round-robin grant:
  - A lone valid requester wins.
  - If both are valid, the requester not granted last wins.
  - The last-grant pointer SHALL reset to 1, so r0 wins first after reset.
REQ-006 On accept (cycle T), the block SHALL latch we, addr, size, wdata and the grant index. Next state SHALL be RESP for size 11, else BEAT0.
REQ-007 Requesters SHALL hold fields stable while valid and not ready. Dropping valid before ready is legal and SHALL discard the request.
REQ-008 Definitions: off = addr[1:0]; n = 1, 2 or 4 bytes; split when off + n > 4.
REQ-009 BEAT0 (T+1) SHALL drive:
  - mem_en = 1; mem_we = latched we; mem_addr = {addr[31:2], 00};
  - mem_be = ((1<<n) - 1) << off, truncated to 4 bits;
  - mem_wdata = wdata << 8*off, truncated.
  Next state SHALL be BEAT1 if split, else RESP.
REQ-010 BEAT1 (T+2, split only) SHALL drive:
  - mem_en = 1; mem_addr = {addr[31:2], 00} + 4, wrapping modulo 2^32;
  - mem_be = ((1<<n) - 1) >> (4 - off);
  - mem_wdata = wdata >> 8*(4 - off).
  Next state SHALL be RESP.
REQ-011 For loads, the block SHALL capture mem_rdata in the cycle after BEAT0 into beat0 data d0.
REQ-012 RESP SHALL assert rsp_valid[grant] for exactly one cycle, then return to IDLE.
  - Aligned load: rsp_rdata = (mem_rdata >> 8*off) masked to n bytes.
  - Split load: rsp_rdata = ((d0 >> 8*off) | (mem_rdata << 8*(4 - off))) masked to n bytes.
  - Store or illegal size: rsp_rdata = 0.
REQ-013 rsp_err SHALL be 1 only in RESP reached from an illegal size. No mem_en SHALL occur for that request.
REQ-014 Latency from accept T: aligned RESP at T+2; split RESP at T+3; illegal RESP at T+1. The next accept is possible at the cycle after RESP.
REQ-015 mem_en SHALL be 0 in IDLE and RESP. When mem_en = 0, mem_we, mem_be and mem_wdata SHALL be 0.
REQ-016 A requester whose valid arrives during a transaction SHALL wait. The grant decision SHALL be made only in IDLE.

Reset
REQ-017 rst SHALL force at the next edge:
  - state IDLE; last-grant pointer 1; d0 and latched request cleared;
  - all outputs 0 (req_ready, rsp_valid, rsp_err, rsp_rdata, mem_*).
REQ-018 rst mid-transaction SHALL abandon the transaction with no rsp_valid. A BEAT0 write already issued is not undone.

Verification
REQ-019 Aligned word store, r0, addr 0x100, data 0xDEADBEEF -> T+1: mem_en = 1, mem_we = 1, addr 0x100, be 1111, wdata 0xDEADBEEF; T+2: rsp_valid = 01.
REQ-020 Split word load, r1, addr 0x203; memory [0x200] = 0x44332211, [0x204] = 0x88776655 -> beats 0x200/be 1000 then 0x204/be 0111; T+3: rsp_valid = 10, rsp_rdata 0x77665544.
REQ-021 Split half store, r0, addr 0x13, data 0xABCD -> beat0 0x10/be 1000/wdata 0xCD000000; beat1 0x14/be 0001/wdata 0x000000AB.
REQ-022 Both valid continuously after reset -> grants r0, r1, r0, r1. req_ready is never 11.
REQ-023 Byte load at 0xFFFFFFFF with word 0xAA000000 -> be 1000, rsp_rdata 0x000000AA. A word load at 0xFFFFFFFE -> beat1 mem_addr 0x00000000.
REQ-024 req_size 11 -> no mem_en; T+1: rsp_valid and rsp_err = 1, rsp_rdata 0. Also: rst asserted in BEAT1 -> next cycle all outputs 0, state IDLE, no rsp_valid.
